// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS31 definitions for the wide generator/checker pair.
//   PRBS_ORDER / PRBS_TAP : polynomial x^31 + x^28 + 1
//   PRBS_MAX_W            : widest word prbs_advance can produce
//   chk_state_t           : checker FSM states
//   prbs_advance()        : steps a 31-bit state by 'width' bits and returns
//                           the new state plus the emitted word
package prbs_pkg;

  localparam int PRBS_ORDER = 31;
  localparam int PRBS_TAP   = 28;
  localparam int PRBS_MAX_W = 128;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  typedef struct packed {
    logic [PRBS_ORDER-1:0] state;
    logic [PRBS_MAX_W-1:0] word;
  } prbs_adv_t;

  // state[0] is the newest bit, state[30] the oldest. The emitted word is
  // right-aligned: word[width-1] is the earliest bit, word[0] the latest.
  function automatic prbs_adv_t prbs_advance(input logic [PRBS_ORDER-1:0] state,
                                             input int width);
    prbs_adv_t r;
    logic      b;
    r.state = state;
    r.word  = '0;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < width) begin
        b       = r.state[PRBS_ORDER-1] ^ r.state[PRBS_TAP-1];
        r.state = {r.state[PRBS_ORDER-2:0], b};
        r.word  = {r.word[PRBS_MAX_W-2:0], b};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_popcount.sv
// prbs_popcount: balanced binary adder tree counting set bits.
//   bits  : input vector
//   count : number of ones in bits
// Tree shape keeps the depth at log2(WIDTH) so a register can later be cut
// in at any level.
module prbs_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int P  = 1 << $clog2(WIDTH);

  logic [CW-1:0] node [1:2*P-1];

  always_comb begin
    for (int k = 1; k < 2*P; k++) node[k] = '0;
    for (int i = 0; i < WIDTH; i++) node[P+i] = CW'(bits[i]);
    for (int k = P-1; k >= 1; k--) node[k] = node[2*k] + node[2*k+1];
    count = node[1];
  end

endmodule

// File: rtl/prbs_wide_check.sv
// prbs_wide_check: parallel PRBS31 receive checker with self-synchronisation.
//   clk, reset      : clock, async active-high reset
//   data_valid/data : received word, data[DATA_WIDTH-1] earliest in time
//   clear_counters  : sync clear of bit_count/err_count
//   locked          : FSM in LOCKED
//   word_valid      : word_errors valid (LOCKED words only)
//   word_errors     : mismatching bits in the checked word
//   bit_count       : bits checked while locked
//   err_count       : bit errors while locked, saturating
// Latency: word sampled at cycle N appears on the outputs at N+2.
module prbs_wide_check
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int BAD_THRESH   = DATA_WIDTH/4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            data_valid,
  input  logic [DATA_WIDTH-1:0]           data,
  input  logic                            clear_counters,
  output logic                            locked,
  output logic                            word_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0] word_errors,
  output logic [63:0]                     bit_count,
  output logic [31:0]                     err_count
);

  localparam int EW = $clog2(DATA_WIDTH+1);
  localparam int MW = $clog2(LOCK_COUNT+1);
  localparam int BW = $clog2(UNLOCK_COUNT+1);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  chk_state_t            state_q, state_d;
  logic [MW-1:0]         match_cnt_q, match_cnt_d;
  logic [BW-1:0]         bad_cnt_q, bad_cnt_d;
  logic [PRBS_ORDER-1:0] hist_q, hist_d;
  logic [PRBS_ORDER-1:0] lfsr_q, lfsr_d;
  logic                  word_valid_q, word_valid_d;
  logic [EW-1:0]         word_errors_q, word_errors_d;
  logic [63:0]           bit_count_q, bit_count_d;
  logic [31:0]           err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0] exp_search, exp_ref, mism;
  logic [PRBS_ORDER-1:0] sh, hist_shift;
  prbs_adv_t             adv;
  logic [EW-1:0]         errs;
  logic [32:0]           err_sum;
  logic                  unused_adv;

  assign data_d  = data;
  assign valid_d = data_valid;

  // Expected bits in both modes. In SEARCH the taps come from received bits,
  // including earlier bits of this same word; in LOCKED from the reference.
  always_comb begin
    exp_search = '0;
    sh         = hist_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      exp_search[DATA_WIDTH-1-i] = sh[PRBS_ORDER-1] ^ sh[PRBS_TAP-1];
      sh = {sh[PRBS_ORDER-2:0], data_q[DATA_WIDTH-1-i]};
    end
    hist_shift = sh;
    adv        = prbs_advance(lfsr_q, DATA_WIDTH);
    exp_ref    = adv.word[DATA_WIDTH-1:0];
    mism       = data_q ^ ((state_q == LOCKED) ? exp_ref : exp_search);
  end

  assign unused_adv = ^adv.word;

  prbs_popcount #(.WIDTH(DATA_WIDTH)) u_pop (
    .bits  (mism),
    .count (errs)
  );

  always_comb begin
    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    hist_d        = hist_q;
    lfsr_d        = lfsr_q;
    word_valid_d  = 1'b0;
    word_errors_d = '0;
    bit_count_d   = bit_count_q;
    err_count_d   = err_count_q;
    err_sum       = {1'b0, err_count_q} + 33'(errs);

    if (valid_q) begin
      hist_d = hist_shift;
      if (state_q == SEARCH) begin
        // Zero history predicts zeros, so all-zero input would self-match.
        if (errs == '0 && hist_q != '0) match_cnt_d = match_cnt_q + MW'(1);
        else                            match_cnt_d = '0;
        if (match_cnt_d == MW'(LOCK_COUNT)) begin
          state_d     = LOCKED;
          lfsr_d      = hist_shift;
          match_cnt_d = '0;
          bad_cnt_d   = '0;
        end
      end else begin
        lfsr_d        = adv.state;
        word_valid_d  = 1'b1;
        word_errors_d = errs;
        bit_count_d   = bit_count_q + 64'(DATA_WIDTH);
        err_count_d   = err_sum[32] ? '1 : err_sum[31:0];
        if (errs >= EW'(BAD_THRESH)) begin
          bad_cnt_d = bad_cnt_q + BW'(1);
          if (bad_cnt_d == BW'(UNLOCK_COUNT)) begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            bad_cnt_d   = '0;
          end
        end else begin
          bad_cnt_d = '0;
        end
      end
    end

    if (clear_counters) begin
      bit_count_d = '0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q        <= '0;
      valid_q       <= 1'b0;
      state_q       <= SEARCH;
      match_cnt_q   <= '0;
      bad_cnt_q     <= '0;
      hist_q        <= '0;
      lfsr_q        <= '0;
      word_valid_q  <= 1'b0;
      word_errors_q <= '0;
      bit_count_q   <= '0;
      err_count_q   <= '0;
    end else begin
      data_q        <= data_d;
      valid_q       <= valid_d;
      state_q       <= state_d;
      match_cnt_q   <= match_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      hist_q        <= hist_d;
      lfsr_q        <= lfsr_d;
      word_valid_q  <= word_valid_d;
      word_errors_q <= word_errors_d;
      bit_count_q   <= bit_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign word_valid  = word_valid_q;
  assign word_errors = word_errors_q;
  assign bit_count   = bit_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_prbs_wide_check.sv
// tb_prbs_wide_check: scoreboard bench for prbs_wide_check (DATA_WIDTH=32).
module tb_prbs_wide_check;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          data_valid;
  logic [W-1:0]  data;
  logic          clear_counters;
  logic          locked;
  logic          word_valid;
  logic [5:0]    word_errors;
  logic [63:0]   bit_count;
  logic [31:0]   err_count;

  always #5 clk = ~clk;

  prbs_wide_check dut (
    .clk            (clk),
    .reset          (reset),
    .data_valid     (data_valid),
    .data           (data),
    .clear_counters (clear_counters),
    .locked         (locked),
    .word_valid     (word_valid),
    .word_errors    (word_errors),
    .bit_count      (bit_count),
    .err_count      (err_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic chk_on;
    int   errs;
    logic lck;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Behavioural model: tracks lock from whether words are genuine PRBS
  logic        m_locked, m_prev_clean;
  int          m_match, m_bad;
  longint      m_bits, m_errs;
  logic [30:0] g;

  task automatic model_reset();
    m_locked = 0; m_prev_clean = 0; m_match = 0; m_bad = 0;
    m_bits = 0; m_errs = 0;
    sbq.delete();
  endtask

  task automatic model_word(input logic clean, input int inj);
    exp_t e;
    e.chk_on = m_locked;
    e.errs   = m_locked ? inj : 0;
    if (m_locked) begin
      m_bits += W;
      m_errs += inj;
      if (inj >= W/4) begin
        m_bad++;
        if (m_bad == 4) begin m_locked = 0; m_match = 0; m_bad = 0; end
      end else m_bad = 0;
    end else begin
      if (clean && m_prev_clean) m_match++;
      else m_match = 0;
      if (m_match == 16) begin m_locked = 1; m_match = 0; m_bad = 0; end
    end
    m_prev_clean = clean;
    e.lck = m_locked;
    sbq.push_back(e);
  endtask

  task automatic next_prbs(output logic [W-1:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < W; i++) begin
      b = g[30] ^ g[27];
      g = {g[29:0], b};
      w[W-1-i] = b;
    end
  endtask

  // kind: 0 clean, 1 flip data[5], 2 inverted, 3 all-zero
  task automatic cyc(input logic vld, input int kind, input logic clr);
    logic [W-1:0] w, pw;
    logic         clean;
    int           inj;
    if (clr) begin m_bits = 0; m_errs = 0; end
    clean = 0; inj = 0; w = $urandom;
    if (vld) begin
      next_prbs(pw);
      w = pw;
      case (kind)
        0: clean = 1;
        1: begin w[5] = ~w[5]; inj = 1; end
        2: begin w = ~w; inj = W; end
        default: begin w = '0; inj = $countones(pw); end
      endcase
      model_word(clean, inj);
    end
    data_valid = vld; data = w; clear_counters = clr;
    @(posedge clk); #1;
  endtask

  // Output monitor: a word sampled at edge E shows at the edge after
  logic [1:0] vd;
  always @(posedge clk or posedge reset) begin
    if (reset) vd <= '0;
    else       vd <= {vd[0], data_valid};
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (vd[1]) begin
        if (sbq.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else begin
          mon_e = sbq.pop_front();
          chk("wv", word_valid, mon_e.chk_on);
          if (mon_e.chk_on) chk("werr", word_errors, mon_e.errs);
          chk("lock", locked, mon_e.lck);
        end
      end else begin
        chk("wv_idle", word_valid, 0);
      end
    end
  end

  initial begin
    reset = 1; data_valid = 0; data = '0; clear_counters = 0;
    g = 31'h2A5C_39E1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_wv", word_valid, 0);
    chk("rst_werr", word_errors, 0);
    chk("rst_bits", bit_count, 0);
    chk("rst_errs", err_count, 0);
    reset = 0;

    // Clean contiguous stream: lock, then 1000 checked words
    for (int i = 0; i < 17 + 1000; i++) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("t1_bits", bit_count, 64'd32000);
    chk("t1_errs", err_count, 0);
    chk("t1_lock", locked, 1);

    // Single bit error
    cyc(1, 1, 0);
    repeat (5) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("t2_errs", err_count, 1);
    chk("t2_bits", bit_count, m_bits);
    chk("t2_lock", locked, 1);

    // Four fully inverted words drop lock, clean stream relocks
    repeat (4) cyc(1, 2, 0);
    repeat (30) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("t4_errs", err_count, 129);
    chk("t4_bits", bit_count, m_bits);
    chk("t4_lock", locked, 1);

    // Clear coincident with an erroneous word's update
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    chk("clr_bits", bit_count, 0);
    chk("clr_errs", err_count, 0);
    chk("clr_lock", locked, 1);
    repeat (3) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("clr_bits2", bit_count, m_bits);

    // Asynchronous reset while locked
    repeat (5) cyc(1, 0, 0);
    data_valid = 0;
    #3 reset = 1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_wv", word_valid, 0);
    chk("arst_bits", bit_count, 0);
    chk("arst_errs", err_count, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;

    // Stalled clean stream
    for (int i = 0; i < 400; i++) cyc(1'($urandom_range(0, 1)), 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("t3_lock", locked, 1);
    chk("t3_errs", err_count, 0);
    chk("t3_bits", bit_count, m_bits);

    // All-zero input never locks
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 100; i++) cyc(1, 3, 0);
    repeat (3) cyc(0, 0, 0);
    chk("t5_lock", locked, 0);
    chk("t5_bits", bit_count, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
